// File: rtl/branch_predictor_pkg.sv
// ----------------------------------------------------------------------------
// branch_predictor_pkg
// Shared definitions for the BTB/BHT branch predictor:
//   - default table depth and the derived index/tag widths
//   - 2-bit saturating counter encodings
//   - bit positions inside the two-bit Pred_Error redirect vector
//   - saturating counter update helper
// ----------------------------------------------------------------------------
package branch_predictor_pkg;

    localparam int ENTRIES_DEF = 64;
    localparam int IDX_W       = $clog2(ENTRIES_DEF);
    localparam int TAG_W       = 32 - IDX_W - 2;

    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } cnt_t;

    // Pred_Error bit positions
    localparam int PE_TGT_BIT = 0;  // redirect to BranchTarget
    localparam int PE_SEQ_BIT = 1;  // redirect to PCE+4

    // Saturating 2-bit counter step toward taken / not-taken.
    function automatic cnt_t cnt_next(input cnt_t c, input logic taken);
        cnt_t n;
        n = c;
        if (taken) begin
            if (c != CNT_ST) n = cnt_t'(c + 2'b01);
        end else begin
            if (c != CNT_SNT) n = cnt_t'(c - 2'b01);
        end
        return n;
    endfunction

endpackage

// File: rtl/branch_predictor_btb_table.sv
// ----------------------------------------------------------------------------
// btb_table
// Direct-mapped storage for the branch predictor. Each entry holds a valid
// bit, tag, target and 2-bit saturating counter.
//
// Ports:
//   i_clk, i_rst        clock / synchronous active-high reset (clears table)
//   i_rd_pc             fetch PC for the asynchronous lookup port
//   o_rd_hit            entry valid and tag matches i_rd_pc
//   o_rd_cnt            counter of the indexed entry
//   o_rd_target         target of the indexed entry
//   i_wr_pc             execute PC for the synchronous update port
//   i_wr_br             resolved conditional branch: train or allocate
//   i_wr_taken          branch outcome
//   i_wr_target         resolved branch target
//   i_wr_inv            invalidate the entry if its tag matches i_wr_pc
//
// The read port sees the contents before this cycle's write, so a fetch and
// a resolution that share an index observe pre-update state.
// ----------------------------------------------------------------------------
module btb_table
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = ENTRIES_DEF,
    parameter int IDX_W_P = $clog2(ENTRIES),
    parameter int TAG_W_P = 32 - IDX_W_P - 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_rd_pc,
    output logic        o_rd_hit,
    output logic [1:0]  o_rd_cnt,
    output logic [31:0] o_rd_target,
    input  logic [31:0] i_wr_pc,
    input  logic        i_wr_br,
    input  logic        i_wr_taken,
    input  logic [31:0] i_wr_target,
    input  logic        i_wr_inv
);

    logic               r_valid  [ENTRIES];
    logic [TAG_W_P-1:0] r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];
    cnt_t               r_cnt    [ENTRIES];

    logic [IDX_W_P-1:0] w_rd_idx;
    logic [TAG_W_P-1:0] w_rd_tag;
    logic [IDX_W_P-1:0] w_wr_idx;
    logic [TAG_W_P-1:0] w_wr_tag;
    logic               w_wr_hit;
    logic               w_unused_pc_lsb;

    assign w_rd_idx = i_rd_pc[IDX_W_P+1:2];
    assign w_rd_tag = i_rd_pc[31:IDX_W_P+2];
    assign w_wr_idx = i_wr_pc[IDX_W_P+1:2];
    assign w_wr_tag = i_wr_pc[31:IDX_W_P+2];

    // Instructions are word aligned; the low PC bits carry no information.
    assign w_unused_pc_lsb = ^{i_rd_pc[1:0], i_wr_pc[1:0]};

    assign o_rd_hit    = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
    assign o_rd_cnt    = r_cnt[w_rd_idx];
    assign o_rd_target = r_target[w_rd_idx];

    assign w_wr_hit = r_valid[w_wr_idx] && (r_tag[w_wr_idx] == w_wr_tag);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_cnt[i]    <= CNT_WNT;
            end
        end else if (i_wr_br) begin
            if (w_wr_hit) begin
                r_cnt[w_wr_idx] <= cnt_next(r_cnt[w_wr_idx], i_wr_taken);
                if (i_wr_taken) r_target[w_wr_idx] <= i_wr_target;
            end else if (i_wr_taken) begin
                // Only taken branches earn a slot; a not-taken miss would
                // predict the fall-through path anyway.
                r_valid[w_wr_idx]  <= 1'b1;
                r_tag[w_wr_idx]    <= w_wr_tag;
                r_target[w_wr_idx] <= i_wr_target;
                r_cnt[w_wr_idx]    <= CNT_WT;
            end
        end else if (i_wr_inv && w_wr_hit) begin
            // Entry predicted taken for something that is not a branch.
            r_valid[w_wr_idx] <= 1'b0;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// ----------------------------------------------------------------------------
// branch_predictor
// Direct-mapped BTB + 2-bit BHT predictor for a 5-stage pipeline.
//
// Ports:
//   clk, rst                 clock / synchronous active-high reset
//   PCF                      fetch PC (lookup address)
//   StallD, FlushD           decode pipeline register controls
//   StallE, FlushE           execute pipeline register controls
//   PCE                      execute PC (update address)
//   IsBranchE                conditional branch in E
//   BranchE                  branch resolved taken
//   BranchTarget             resolved target
//   PredF, NPC_PredF         prediction for PCF (combinational)
//   Pred_Error               bit0: redirect to BranchTarget,
//                            bit1: redirect to PCE+4
//   BranchCnt, MissCnt       resolved branch / misprediction counters
//
// The prediction made in F travels with the instruction through D and E so
// that E can compare it against the actual outcome. An instruction resolves
// exactly once: on the cycle it is valid in E and E is not stalled.
// ----------------------------------------------------------------------------
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = ENTRIES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        StallE,
    input  logic        FlushE,
    input  logic [31:0] PCE,
    input  logic        IsBranchE,
    input  logic        BranchE,
    input  logic [31:0] BranchTarget,
    output logic        PredF,
    output logic [31:0] NPC_PredF,
    output logic [1:0]  Pred_Error,
    output logic [31:0] BranchCnt,
    output logic [31:0] MissCnt
);

    localparam int L_IDX_W = $clog2(ENTRIES);
    localparam int L_TAG_W = 32 - L_IDX_W - 2;

    logic        w_hit_f;
    logic [1:0]  w_cnt_f;
    logic [31:0] w_tgt_f;
    logic        w_pred_f;
    logic [31:0] w_npc_f;

    logic        r_pred_p1;
    logic [31:0] r_npc_p1;
    logic        r_pred_p2;
    logic [31:0] r_npc_p2;
    logic        r_vld_p2;

    logic        w_res;
    logic        w_taken_br;
    logic [1:0]  w_perr;
    logic        w_wr_br;
    logic        w_wr_inv;

    logic [31:0] r_branch_cnt;
    logic [31:0] r_miss_cnt;

    btb_table #(
        .ENTRIES (ENTRIES),
        .IDX_W_P (L_IDX_W),
        .TAG_W_P (L_TAG_W)
    ) u_table (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rd_pc     (PCF),
        .o_rd_hit    (w_hit_f),
        .o_rd_cnt    (w_cnt_f),
        .o_rd_target (w_tgt_f),
        .i_wr_pc     (PCE),
        .i_wr_br     (w_wr_br),
        .i_wr_taken  (BranchE),
        .i_wr_target (BranchTarget),
        .i_wr_inv    (w_wr_inv)
    );

    // ---- F: lookup (forced quiet while reset is asserted) ----
    assign w_pred_f  = ~rst & w_hit_f & w_cnt_f[1];
    assign w_npc_f   = w_pred_f ? w_tgt_f : 32'h0;
    assign PredF     = w_pred_f;
    assign NPC_PredF = w_npc_f;

    // ---- F -> D ----
    always_ff @(posedge clk) begin
        if (rst || FlushD) begin
            r_pred_p1 <= 1'b0;
            r_npc_p1  <= 32'h0;
        end else if (!StallD) begin
            r_pred_p1 <= w_pred_f;
            r_npc_p1  <= w_npc_f;
        end
    end

    // ---- D -> E ----
    always_ff @(posedge clk) begin
        if (rst || FlushE) begin
            r_pred_p2 <= 1'b0;
            r_npc_p2  <= 32'h0;
            r_vld_p2  <= 1'b0;
        end else if (!StallE) begin
            r_pred_p2 <= r_pred_p1;
            r_npc_p2  <= r_npc_p1;
            r_vld_p2  <= 1'b1;
        end
    end

    // ---- E: resolution ----
    assign w_res      = ~rst & r_vld_p2 & ~StallE;
    assign w_taken_br = IsBranchE & BranchE;

    always_comb begin
        w_perr = 2'b00;
        // Taken branch with no prediction, or predicted to the wrong target.
        w_perr[PE_TGT_BIT] = w_res & w_taken_br &
                             (~r_pred_p2 | (r_npc_p2 != BranchTarget));
        // Predicted taken but the instruction falls through.
        w_perr[PE_SEQ_BIT] = w_res & r_pred_p2 & ~w_taken_br;
    end

    assign Pred_Error = w_perr;

    assign w_wr_br  = w_res & IsBranchE;
    assign w_wr_inv = w_res & r_pred_p2 & ~IsBranchE;

    // ---- E: statistics ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_branch_cnt <= 32'h0;
            r_miss_cnt   <= 32'h0;
        end else begin
            if (w_wr_br)      r_branch_cnt <= r_branch_cnt + 32'h1;
            if (|w_perr)      r_miss_cnt   <= r_miss_cnt + 32'h1;
        end
    end

    assign BranchCnt = r_branch_cnt;
    assign MissCnt   = r_miss_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] PCF = 32'h0;
    logic        StallD = 1'b0, FlushD = 1'b0, StallE = 1'b0, FlushE = 1'b0;
    logic [31:0] PCE = 32'h0;
    logic        IsBranchE = 1'b0, BranchE = 1'b0;
    logic [31:0] BranchTarget = 32'h0;
    logic        PredF;
    logic [31:0] NPC_PredF;
    logic [1:0]  Pred_Error;
    logic [31:0] BranchCnt, MissCnt;

    int n_cmp = 0;
    int n_fail = 0;

    branch_predictor #(.ENTRIES(64)) dut (
        .clk(clk), .rst(rst), .PCF(PCF),
        .StallD(StallD), .FlushD(FlushD), .StallE(StallE), .FlushE(FlushE),
        .PCE(PCE), .IsBranchE(IsBranchE), .BranchE(BranchE), .BranchTarget(BranchTarget),
        .PredF(PredF), .NPC_PredF(NPC_PredF), .Pred_Error(Pred_Error),
        .BranchCnt(BranchCnt), .MissCnt(MissCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Table: 64 entries, index = PC bits 7:2, tag = PC bits 31:8.
    bit          mv   [64];
    logic [31:0] mtag [64];
    logic [31:0] mtgt [64];
    int          mcnt [64];
    // Prediction in flight: D holds what F said one instruction ago, E the one before.
    bit          d_pred, e_pred, e_vld;
    logic [31:0] d_npc, e_npc;
    logic [31:0] mbc, mmc;

    function automatic int ix(input logic [31:0] pc);
        return int'(pc[7:2]);
    endfunction

    int          fi, ei;
    bit          ex_pred, res, e_hit, taken;
    logic [31:0] ex_npc;
    logic [1:0]  ex_err;

    initial begin
        forever begin
            @(negedge clk);
            fi = ix(PCF);
            ex_pred = !rst && mv[fi] && mtag[fi] == (PCF >> 8) && mcnt[fi] >= 2;
            ex_npc  = ex_pred ? mtgt[fi] : 32'h0;
            res     = !rst && e_vld && !StallE;
            taken   = IsBranchE && BranchE;
            ex_err  = 2'b00;
            if (res && taken && (!e_pred || e_npc != BranchTarget)) ex_err = 2'b01;
            if (res && e_pred && !taken)                            ex_err = 2'b10;

            chk("PredF", {31'h0, PredF}, {31'h0, ex_pred});
            chk("NPC_PredF", NPC_PredF, ex_npc);
            chk("Pred_Error", {30'h0, Pred_Error}, {30'h0, ex_err});
            if (!rst) begin
                chk("BranchCnt", BranchCnt, mbc);
                chk("MissCnt", MissCnt, mmc);
            end

            // advance to the state after this clock edge
            if (rst) begin
                for (int i = 0; i < 64; i++) begin
                    mv[i] = 0; mtag[i] = 0; mtgt[i] = 0; mcnt[i] = 1;
                end
                d_pred = 0; d_npc = 0; e_pred = 0; e_npc = 0; e_vld = 0;
                mbc = 0; mmc = 0;
            end else begin
                ei = ix(PCE);
                e_hit = mv[ei] && mtag[ei] == (PCE >> 8);
                if (res && IsBranchE) begin
                    mbc = mbc + 1;
                    if (e_hit) begin
                        mcnt[ei] = BranchE ? ((mcnt[ei] < 3) ? mcnt[ei] + 1 : 3)
                                           : ((mcnt[ei] > 0) ? mcnt[ei] - 1 : 0);
                        if (BranchE) mtgt[ei] = BranchTarget;
                    end else if (BranchE) begin
                        mv[ei] = 1; mtag[ei] = PCE >> 8; mtgt[ei] = BranchTarget; mcnt[ei] = 2;
                    end
                end else if (res && e_pred && e_hit) begin
                    mv[ei] = 0;
                end
                if (ex_err != 2'b00) mmc = mmc + 1;
                if (FlushE) begin
                    e_pred = 0; e_npc = 0; e_vld = 0;
                end else if (!StallE) begin
                    e_pred = d_pred; e_npc = d_npc; e_vld = 1;
                end
                if (FlushD) begin
                    d_pred = 0; d_npc = 0;
                end else if (!StallD) begin
                    d_pred = ex_pred; d_npc = ex_npc;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic settle;
        @(negedge clk); #1;
    endtask

    // Fetch pc, then resolve it in E two cycles later with no stalls.
    task automatic do_branch(input logic [31:0] pc, input logic isb, input logic tk,
                             input logic [31:0] tgt, input logic ep,
                             input logic [31:0] enpc, input logic [1:0] eerr);
        PCF = pc; IsBranchE = 0; BranchE = 0;
        settle;
        chk("lit_PredF", {31'h0, PredF}, {31'h0, ep});
        chk("lit_NPC", NPC_PredF, enpc);
        tick;
        PCF = pc + 4;
        tick;
        PCF = pc + 8; PCE = pc; IsBranchE = isb; BranchE = tk; BranchTarget = tgt;
        settle;
        chk("lit_PredErr", {30'h0, Pred_Error}, {30'h0, eerr});
        tick;
        IsBranchE = 0; BranchE = 0;
    endtask

    initial begin
        rst = 1;
        tick; tick;
        rst = 0; PCF = 32'h100;
        settle;
        chk("rst_PredF", {31'h0, PredF}, 32'h0);
        chk("rst_NPC", NPC_PredF, 32'h0);
        chk("rst_BranchCnt", BranchCnt, 32'h0);
        chk("rst_MissCnt", MissCnt, 32'h0);
        tick;

        // taken twice to 0x80
        do_branch(32'h100, 1, 1, 32'h80, 0, 32'h0, 2'b01);
        chk("mdl_cnt_alloc", mcnt[0], 2);
        do_branch(32'h100, 1, 1, 32'h80, 1, 32'h80, 2'b00);
        chk("mdl_cnt_sat", mcnt[0], 3);
        settle;
        chk("lit_BranchCnt2", BranchCnt, 32'd2);
        chk("lit_MissCnt1", MissCnt, 32'd1);
        tick;

        // not taken twice
        do_branch(32'h100, 1, 0, 32'h80, 1, 32'h80, 2'b10);
        chk("mdl_cnt_dec1", mcnt[0], 2);
        do_branch(32'h100, 1, 0, 32'h80, 1, 32'h80, 2'b10);
        chk("mdl_cnt_dec2", mcnt[0], 1);
        // weakly not taken: no prediction, taken -> retrain to 10
        do_branch(32'h100, 1, 1, 32'h80, 0, 32'h0, 2'b01);
        // wrong target
        do_branch(32'h100, 1, 1, 32'h90, 1, 32'h80, 2'b01);
        chk("mdl_tgt", mtgt[0], 32'h90);
        // non-branch aliasing a taken entry
        do_branch(32'h100, 0, 0, 32'h0, 1, 32'h90, 2'b10);
        do_branch(32'h100, 0, 0, 32'h0, 0, 32'h0, 2'b00);

        // StallE over a mispredicted branch
        PCF = 32'h240; tick;
        PCF = 32'h244; tick;
        PCF = 32'h248; PCE = 32'h240; IsBranchE = 1; BranchE = 1; BranchTarget = 32'h300;
        StallE = 1; StallD = 1;
        for (int k = 0; k < 3; k++) begin
            settle;
            chk("stall_PredErr", {30'h0, Pred_Error}, 32'h0);
            tick;
        end
        StallE = 0; StallD = 0;
        settle;
        chk("release_PredErr", {30'h0, Pred_Error}, 32'h1);
        tick;
        IsBranchE = 0; BranchE = 0;
        settle;
        chk("stall_MissCnt", MissCnt, 32'd7);
        chk("stall_BranchCnt", BranchCnt, 32'd7);
        tick;

        // FlushE together with StallE: no error, entry kept
        PCF = 32'h240;
        settle;
        chk("flush_pred", {31'h0, PredF}, 32'h1);
        tick;
        PCF = 32'h244; tick;
        PCF = 32'h248; PCE = 32'h240; IsBranchE = 0; BranchE = 0; StallE = 1; FlushE = 1;
        settle;
        chk("flush_PredErr_a", {30'h0, Pred_Error}, 32'h0);
        tick;
        StallE = 0; FlushE = 0;
        settle;
        chk("flush_PredErr_b", {30'h0, Pred_Error}, 32'h0);
        tick;
        PCF = 32'h240;
        settle;
        chk("flush_MissCnt", MissCnt, 32'd7);
        chk("flush_kept", {31'h0, PredF}, 32'h1);
        tick;

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            PCF          = ($urandom_range(1, 3) << 8) | ($urandom_range(0, 3) << 2);
            PCE          = ($urandom_range(1, 3) << 8) | ($urandom_range(0, 3) << 2);
            IsBranchE    = ($urandom_range(0, 2) != 0);
            BranchE      = $urandom_range(0, 1) == 1;
            BranchTarget = 32'h1000 + ($urandom_range(0, 2) << 4);
            StallD       = ($urandom_range(0, 5) == 0);
            FlushD       = ($urandom_range(0, 7) == 0);
            StallE       = ($urandom_range(0, 5) == 0);
            FlushE       = ($urandom_range(0, 7) == 0);
            rst          = ($urandom_range(0, 199) == 0);
            tick;
        end
        rst = 0; StallD = 0; FlushD = 0; StallE = 0; FlushE = 0; IsBranchE = 0;
        tick; tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
